// File: rtl/fx_mix_out.sv
// Output stage of the vibrato effect: grants the effect a turn per dry sample,
// blends wet/dry, applies master gain with saturation and hands off via valid/ready.
module fx_mix_out #(
  parameter int DW      = 24,
  parameter int TIMEOUT = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_stb,
  input  logic          fx_enable,
  output logic          fx_my_turn,
  input  logic          fx_done,
  input  logic [DW-1:0] fx_data,
  input  logic [8:0]    wet_level,
  input  logic [7:0]    gain,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          clip,
  output logic [15:0]   drop_cnt,
  output logic          fx_timeout
);

  localparam int MW = DW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [33:0] MAXV = (34'sd1 <<< (DW - 1)) - 34'sd1;
  localparam logic signed [33:0] MINV = -(34'sd1 <<< (DW - 1));

  typedef enum logic [2:0] {IDLE, WAIT_FX, MIX, GAIN, SAT, HOLD} state_t;

  state_t                state_q;
  logic signed [DW-1:0]  dry_q, wet_q;
  logic        [DW-1:0]  out_data_q;
  logic        [8:0]     wl_q;
  logic        [7:0]     gain_q;
  logic        [CW-1:0]  cnt_q;
  logic signed [MW-1:0]  m_q, m_d;
  logic signed [33:0]    g_q, g_d;
  logic                  turn_q, valid_q, clip_q, timeout_q;
  logic        [15:0]    drop_q;

  logic signed [9:0]     wl_s, inv_s;
  logic signed [8:0]     gain_s;
  logic signed [34:0]    acc;
  logic signed [33:0]    g_full;
  logic                  sat_clip;
  logic        [DW-1:0]  sat_val;

  // Returns {clipped, value}: clamps a gained sample into the DW-bit range.
  function automatic logic [DW:0] sat(input logic signed [33:0] g);
    if (g > MAXV)      return {1'b1, 1'b0, {(DW-1){1'b1}}};
    else if (g < MINV) return {1'b1, 1'b1, {(DW-1){1'b0}}};
    else               return {1'b0, g[DW-1:0]};
  endfunction

  assign wl_s   = $signed({1'b0, wl_q});
  assign inv_s  = 10'sd256 - wl_s;
  assign acc    = 35'(dry_q) * 35'(inv_s) + 35'(wet_q) * 35'(wl_s) + 35'sd128;
  assign m_d    = MW'(acc >>> 8);
  assign gain_s = $signed({1'b0, gain_q});
  assign g_full = 34'(m_q) * 34'(gain_s) + 34'sd8;
  assign g_d    = g_full >>> 4;
  assign {sat_clip, sat_val} = sat(g_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dry_q      <= '0;
      wet_q      <= '0;
      out_data_q <= '0;
      wl_q       <= '0;
      gain_q     <= '0;
      cnt_q      <= '0;
      m_q        <= '0;
      g_q        <= '0;
      turn_q     <= 1'b0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      // Any strobe outside IDLE is an overrun; the sample in flight is unaffected.
      if (sample_stb && state_q != IDLE && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
      case (state_q)
        IDLE: if (sample_stb) begin
          dry_q  <= sample_in;
          wl_q   <= (wet_level > 9'd256) ? 9'd256 : wet_level;
          gain_q <= gain;
          cnt_q  <= '0;
          if (fx_enable) begin
            turn_q  <= 1'b1;
            state_q <= WAIT_FX;
          end else begin
            wet_q   <= sample_in;
            state_q <= MIX;
          end
        end
        WAIT_FX: begin
          if (fx_done) begin
            wet_q   <= fx_data;
            turn_q  <= 1'b0;
            state_q <= MIX;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            wet_q     <= dry_q;
            timeout_q <= 1'b1;
            turn_q    <= 1'b0;
            state_q   <= MIX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        MIX: begin
          m_q     <= m_d;
          state_q <= GAIN;
        end
        GAIN: begin
          g_q     <= g_d;
          state_q <= SAT;
        end
        SAT: begin
          out_data_q <= sat_val;
          if (sat_clip) clip_q <= 1'b1;
          valid_q    <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: if (out_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fx_my_turn = turn_q;
  assign out_data   = out_data_q;
  assign out_valid  = valid_q;
  assign clip       = clip_q;
  assign drop_cnt   = drop_q;
  assign fx_timeout = timeout_q;

endmodule
